// File: rtl/aoc_pkg.sv
// Shared types and defaults for the range-sum controller.
// Holds the controller state enum and the default reset-hold length.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef LONG_DATA_WIDTH
`define LONG_DATA_WIDTH 64
`endif

package aoc_pkg;

  localparam int DEF_CC_RST_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    RST_HI,
    RUN_HI,
    RST_LO,
    RUN_LO,
    ACCUM
  } rsc_state_t;

endpackage

// File: rtl/dec_digits.sv
// Decimal digit count of n by power-of-ten compares; 0 yields 0.
// Ports: n (value in), digs (number of decimal digits out).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module dec_digits #(
  parameter int W = `DATA_WIDTH
) (
  input  logic [W-1:0] n,
  output logic [W-1:0] digs
);

  localparam int MAXD = 20;

  logic [63:0] p;

  // digs = number of k with n >= 10^k
  always_comb begin
    p    = 64'd1;
    digs = '0;
    for (int k = 0; k < MAXD; k++) begin
      if (64'(n) >= p) digs = digs + W'(1);
      if (k < MAXD - 1) p = p * 64'd10;
    end
  end

endmodule

// File: rtl/range_sum_ctrl.sv
// Sequences count_combs over [lo,hi] as count(hi) - count(lo-1), summed per batch.
// Ports: clock/reset, range offer (lo,hi,last,valid/ready), cc_* to count_combs, total_sum/range_err/done.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef LONG_DATA_WIDTH
`define LONG_DATA_WIDTH 64
`endif

module range_sum_ctrl
  import aoc_pkg::*;
#(
  parameter int CC_RST_CYCLES = DEF_CC_RST_CYCLES
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [`DATA_WIDTH-1:0]      range_lo,
  input  logic [`DATA_WIDTH-1:0]      range_hi,
  input  logic                        range_last,
  input  logic                        range_valid,
  output logic                        range_ready,
  output logic                        cc_reset,
  output logic [`DATA_WIDTH-1:0]      cc_n_in,
  output logic [`DATA_WIDTH-1:0]      cc_n_digs,
  input  logic [`LONG_DATA_WIDTH-1:0] cc_count,
  input  logic                        cc_valid,
  output logic [`LONG_DATA_WIDTH-1:0] total_sum,
  output logic                        range_err,
  output logic                        done
);

  localparam int DW = `DATA_WIDTH;
  localparam int LW = `LONG_DATA_WIDTH;
  localparam int CW =
    (CC_RST_CYCLES > 1) ? $clog2(CC_RST_CYCLES) : 1;

  rsc_state_t state, state_nx;

  logic [DW-1:0] lo_q;
  logic          last_q;
  logic          fresh_q;
  logic          vld_q;
  logic [LW-1:0] hi_cnt, lo_cnt;
  logic [CW-1:0] rst_cnt;

  logic          accept, bad, rst_end, cc_rise;
  logic          load_n;
  logic [DW-1:0] n_nx, digs_nx;

  assign accept  = range_valid && range_ready;
  assign bad     = range_lo > range_hi;
  assign rst_end = rst_cnt == CW'(CC_RST_CYCLES - 1);
  // a valid left high from the last evaluation is not a result
  assign cc_rise = cc_valid && !vld_q;

  assign load_n = (accept && !bad) ||
                  (state == RUN_HI && cc_rise && lo_q != '0);
  assign n_nx   = (state == IDLE) ? range_hi : lo_q - DW'(1);

  dec_digits #(.W(DW)) u_digs (
    .n    (n_nx),
    .digs (digs_nx)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept) state_nx = bad ? ACCUM : RST_HI;
      RST_HI:
        if (rst_end) state_nx = RUN_HI;
      RUN_HI:
        if (cc_rise)
          state_nx = (lo_q == '0) ? ACCUM : RST_LO;
      RST_LO:
        if (rst_end) state_nx = RUN_LO;
      RUN_LO:
        if (cc_rise) state_nx = ACCUM;
      ACCUM:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    range_ready = (state == IDLE) && !reset;
    cc_reset    = !(state == RUN_HI || state == RUN_LO);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lo_q      <= '0;
      last_q    <= 1'b0;
      fresh_q   <= 1'b0;
      vld_q     <= 1'b0;
      hi_cnt    <= '0;
      lo_cnt    <= '0;
      rst_cnt   <= '0;
      cc_n_in   <= '0;
      cc_n_digs <= '0;
      total_sum <= '0;
      range_err <= 1'b0;
      done      <= 1'b0;
    end else begin
      vld_q     <= cc_valid;
      range_err <= accept && bad;
      if (accept) begin
        lo_q    <= range_lo;
        last_q  <= range_last;
        fresh_q <= done;
        hi_cnt  <= '0;
        lo_cnt  <= '0;
        done    <= 1'b0;
      end
      if (load_n) begin
        cc_n_in   <= n_nx;
        cc_n_digs <= digs_nx;
      end
      if (state == RST_HI || state == RST_LO)
        rst_cnt <= rst_end ? '0 : rst_cnt + CW'(1);
      if (state == RUN_HI && cc_rise) hi_cnt <= cc_count;
      if (state == RUN_LO && cc_rise) lo_cnt <= cc_count;
      if (state == ACCUM) begin
        // first range after a finished batch restarts the sum
        total_sum <= (fresh_q ? '0 : total_sum) +
                     (hi_cnt - lo_cnt);
        done      <= last_q;
      end
    end
  end

endmodule

// File: doc/range_sum_ctrl.md
RANGE_SUM_CTRL -- requirements
Module: range_sum_ctrl

Interface
REQ-001 SHALL have parameter CC_RST_CYCLES, default 2: cycles cc_reset is held high before each count_combs evaluation.
REQ-002 SHALL have port clock, input, 1: single clock, rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high.
REQ-004 SHALL have port range_lo, input, `DATA_WIDTH: inclusive lower bound of an ID range.
REQ-005 SHALL have port range_hi, input, `DATA_WIDTH: inclusive upper bound.
REQ-006 SHALL have port range_last, input, 1: marks the final range of a batch.
REQ-007 SHALL have port range_valid, input, 1: range offer.
REQ-008 SHALL have port range_ready, output, 1: controller can accept a range.
REQ-009 SHALL have port cc_reset, output, 1: drives count_combs reset.
REQ-010 SHALL have port cc_n_in, output, `DATA_WIDTH: drives count_combs n_in.
REQ-011 SHALL have port cc_n_digs, output, `DATA_WIDTH: decimal digit count of cc_n_in, with 0 when cc_n_in is 0.
REQ-012 SHALL have port cc_count, input, `LONG_DATA_WIDTH: count_combs count_out, the sum of invalid IDs <= n.
REQ-013 SHALL have port cc_valid, input, 1: count_combs count_out_valid.
REQ-014 SHALL have port total_sum, output, `LONG_DATA_WIDTH: accumulated batch sum.
REQ-015 SHALL have port range_err, output, 1: one-cycle pulse when an accepted range has lo > hi.
REQ-016 SHALL have port done, output, 1: level; the batch is complete and total_sum is final.

Function
REQ-017 SHALL implement the states IDLE, RST_HI, RUN_HI, RST_LO, RUN_LO, ACCUM.
REQ-018 SHALL assert range_ready only in IDLE; a range is accepted on a cycle with range_valid && range_ready, and lo, hi and last are registered on that cycle.
REQ-019 On accept with lo > hi, SHALL pulse range_err, add 0, and go to ACCUM.
REQ-020 On accept with lo <= hi, SHALL go to RST_HI.
REQ-021 In RST_HI, SHALL assert cc_reset for exactly CC_RST_CYCLES cycles with cc_n_in = hi, then go to RUN_HI.
REQ-022 In RUN_HI, SHALL deassert cc_reset and hold cc_n_in = hi.
REQ-023 In RUN_HI, SHALL capture cc_count into hi_cnt on the first cycle cc_valid is 1, then go to RST_LO.
REQ-024 When lo = 0, SHALL set lo_cnt = 0 and go directly from RUN_HI to ACCUM, with no second evaluation.
REQ-025 In RST_LO and RUN_LO, SHALL behave as RST_HI and RUN_HI but with cc_n_in = lo-1, capture cc_count into lo_cnt, then go to ACCUM.
REQ-026 In ACCUM (one cycle), SHALL update total_sum <= total_sum + (hi_cnt - lo_cnt), mod 2^`LONG_DATA_WIDTH, then go to IDLE.
REQ-027 In ACCUM, SHALL set done = 1 if last was set.
REQ-028 A range accepted while done = 1 SHALL begin a new batch: clear done and overwrite total_sum with that range's contribution, not add to the old sum.
REQ-029 SHALL ignore cc_valid outside RUN_HI and RUN_LO, and ignore a cc_valid that is still high on the first RUN cycle from a previous evaluation; only a 0->1 transition observed in RUN counts.
REQ-030 SHALL hold cc_reset = 1 in IDLE and in ACCUM.
REQ-031 SHALL register cc_n_digs together with cc_n_in, so both are stable for the whole evaluation.
REQ-032 SHALL leave range_valid unsampled outside IDLE, with no backpressure violation possible.

Reset
REQ-033 On reset, outputs SHALL be: range_ready 0, done 0, range_err 0, total_sum 0, cc_reset 1, cc_n_in 0, cc_n_digs 0.
REQ-034 On reset, the state SHALL go to IDLE and hi_cnt/lo_cnt SHALL be cleared.
REQ-035 range_ready SHALL rise on the first cycle after reset is released.
REQ-036 Reset mid-evaluation SHALL abort the range, with no accumulation.

Structure
REQ-037 Package aoc_pkg SHALL hold the state enum rsc_state_t and the default CC_RST_CYCLES.
REQ-038 `DATA_WIDTH and `LONG_DATA_WIDTH SHALL remain the existing global macros.
REQ-039 SHALL contain one sub-module, dec_digits: combinational decimal digit count via power-of-ten compares.
REQ-040 count_combs SHALL be instantiated by the parent, not inside range_sum_ctrl.

Verification (bench uses a behavioural count_combs model: cc_valid rises 7 cycles after cc_reset falls; cc_count = sum of IDs <= n made of a digit string repeated twice)
REQ-041 Range 11-22, last=1 -> cc_n_in 22 then 10; total_sum 33; done=1.
REQ-042 Batch 11-22, 95-115, 998-1012 (last on the third) -> total_sum 33, 132, 1142; done asserts only after the third range.
REQ-043 Range 0-22, last=1 -> exactly one evaluation with n=22 and one cc_reset pulse group; total_sum 33.
REQ-044 Range 50-40 -> range_err pulse; total_sum unchanged; no cc_reset deassertion.
REQ-045 Reset asserted in RUN_LO of range 95-115 -> all outputs at their reset values next cycle; a following range 11-22 with last gives total_sum 33.
REQ-046 After done with total 1142, a new range 95-115 with last -> done falls on accept; total_sum 99.
